// File: rtl/multicycle_maindec.sv
// Multicycle main decoder: Moore FSM sequencing fetch/decode/execute/memory/
// writeback for the gigaHurt MIPS-style datapath, with a memory-wait watchdog.
// Optional feature macro: MULTICYCLE_MAINDEC_JAL_EN (JAL links and jumps in a
// single JALWB state; when undefined, JAL behaves exactly as J and link is 0).
module multicycle_maindec #(
    parameter int unsigned OPW      = 3,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] op,
    input  logic           memready,
    output logic           memreq,
    output logic           memwrite,
    output logic           irwrite,
    output logic           pcwrite,
    output logic           branch,
    output logic           regwrite,
    output logic           regdst,
    output logic           memtoreg,
    output logic           iord,
    output logic           alusrca,
    output logic [1:0]     alusrcb,
    output logic [1:0]     pcsrc,
    output logic [1:0]     aluop,
    output logic           link,
    output logic           done,
    output logic           fault,
    output logic [3:0]     state
);

    localparam int unsigned CW    = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam bit          WD_EN = (WAIT_MAX != 0);

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_LW    = 3'b001;
    localparam logic [2:0] OP_SW    = 3'b010;
    localparam logic [2:0] OP_ADDI  = 3'b011;
    localparam logic [2:0] OP_BEQ   = 3'b101;
    localparam logic [2:0] OP_J     = 3'b110;
    localparam logic [2:0] OP_JAL   = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_JALWB   = 4'd12,
        S_FAULT   = 4'd13
    } state_t;

    state_t        cur;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          is_sw;
    logic          in_wait;
    logic          timeout;
    logic [2:0]    op_lo;
    logic          op_hi_nz;

    // Only the low three opcode bits are meaningful; anything above is illegal.
    assign op_lo    = op[2:0];
    assign op_hi_nz = |(op >> 3);

    // Watchdog fires when the wait count has reached its limit and memory is still busy.
    assign timeout = WD_EN && (cnt == CW'(WAIT_MAX)) && !memready;

    // Next-state decode; op is only looked at in DECODE.
    always_comb begin
        nxt     = S_FETCH;
        in_wait = 1'b0;
        case (cur)
            S_FETCH: begin
                in_wait = 1'b1;
                if (memready)     nxt = S_DECODE;
                else if (timeout) nxt = S_FAULT;
                else              nxt = S_FETCH;
            end
            S_DECODE: begin
                if (op_hi_nz) begin
                    nxt = S_FAULT;
                end else begin
                    case (op_lo)
                        OP_RTYPE:     nxt = S_EXECUTE;
                        OP_LW, OP_SW: nxt = S_MEMADR;
                        OP_ADDI:      nxt = S_ADDIEX;
                        OP_BEQ:       nxt = S_BRANCH;
                        OP_J:         nxt = S_JUMP;
`ifdef MULTICYCLE_MAINDEC_JAL_EN
                        OP_JAL:       nxt = S_JALWB;
`else
                        OP_JAL:       nxt = S_JUMP;
`endif
                        default:      nxt = S_FAULT;
                    endcase
                end
            end
            S_MEMADR:  nxt = is_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                in_wait = 1'b1;
                if (memready)     nxt = S_MEMWB;
                else if (timeout) nxt = S_FAULT;
                else              nxt = S_MEMRD;
            end
            S_MEMWR: begin
                in_wait = 1'b1;
                if (memready)     nxt = S_FETCH;
                else if (timeout) nxt = S_FAULT;
                else              nxt = S_MEMWR;
            end
            S_EXECUTE: nxt = S_ALUWB;
            S_ADDIEX:  nxt = S_ADDIWB;
            default:   nxt = S_FETCH;
        endcase
    end

    // Wait counter restarts on any state change or completed access.
    always_comb begin
        cnt_nxt = '0;
        if (WD_EN && in_wait && !memready && (nxt == cur)) begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    // State, wait counter and the LW/SW choice captured in DECODE.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur   <= S_FETCH;
            cnt   <= '0;
            is_sw <= 1'b0;
        end else begin
            cur <= nxt;
            cnt <= cnt_nxt;
            if (cur == S_DECODE) begin
                is_sw <= (op_lo == OP_SW);
            end
        end
    end

    // Moore output decode, forced to zero while reset is asserted.
    always_comb begin
        memreq   = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        iord     = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        link     = 1'b0;
        done     = 1'b0;
        fault    = 1'b0;
        state    = 4'd0;
        if (!reset) begin
            state = cur;
            case (cur)
                S_FETCH: begin
                    memreq  = 1'b1;
                    alusrcb = 2'b01;
                    irwrite = memready;
                    pcwrite = memready;
                end
                S_DECODE: alusrcb = 2'b11;
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    memreq = 1'b1;
                    iord   = 1'b1;
                end
                S_MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                    done     = 1'b1;
                end
                S_MEMWR: begin
                    memreq   = 1'b1;
                    iord     = 1'b1;
                    memwrite = 1'b1;
                    done     = memready;
                end
                S_EXECUTE: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                end
                S_ALUWB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                    done     = 1'b1;
                end
                S_BRANCH: begin
                    alusrca = 1'b1;
                    aluop   = 2'b01;
                    pcsrc   = 2'b01;
                    branch  = 1'b1;
                    done    = 1'b1;
                end
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_ADDIWB: begin
                    regwrite = 1'b1;
                    done     = 1'b1;
                end
                S_JUMP: begin
                    pcsrc   = 2'b10;
                    pcwrite = 1'b1;
                    done    = 1'b1;
                end
`ifdef MULTICYCLE_MAINDEC_JAL_EN
                S_JALWB: begin
                    regwrite = 1'b1;
                    link     = 1'b1;
                    pcsrc    = 2'b10;
                    pcwrite  = 1'b1;
                    done     = 1'b1;
                end
`endif
                S_FAULT: fault = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_maindec.sv
// Self-checking bench for multicycle_maindec: per-cycle expected state and
// control vector queued when stimulus is driven, checked on the falling edge.
module tb_multicycle_maindec;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] op = 3'b000;
    logic       memready = 1'b1;
    logic       memreq, memwrite, irwrite, pcwrite, branch, regwrite, regdst;
    logic       memtoreg, iord, alusrca, link, done, fault;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state;

    int n_cmp = 0;
    int n_bad = 0;
    int n_step = 0;

    typedef struct {
        int          idx;
        logic [3:0]  st;
        logic [18:0] ctrl;
    } exp_t;

    exp_t sb[$];

    multicycle_maindec #(.OPW(3), .WAIT_MAX(15)) dut (
        .clk(clk), .reset(reset), .op(op), .memready(memready),
        .memreq(memreq), .memwrite(memwrite), .irwrite(irwrite),
        .pcwrite(pcwrite), .branch(branch), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .iord(iord),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
        .link(link), .done(done), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

`ifdef MULTICYCLE_MAINDEC_JAL_EN
    localparam logic [3:0] JAL_ST = 4'd12;
`else
    localparam logic [3:0] JAL_ST = 4'd11;
`endif

    // Control vector the state table calls for, in the order of obs_ctrl below.
    function automatic logic [18:0] exp_ctrl(input logic [3:0] st, input logic mr, input logic rst);
        logic mq, mw, ir, pw, br, rw, rd, mtr, io, sa, lk, dn, ft;
        logic [1:0] sb2, ps, ao;
        {mq, mw, ir, pw, br, rw, rd, mtr, io, sa, lk, dn, ft} = '0;
        sb2 = 2'b00; ps = 2'b00; ao = 2'b00;
        if (!rst) begin
            case (st)
                4'd0:  begin mq = 1; sb2 = 2'b01; ir = mr; pw = mr; end
                4'd1:  sb2 = 2'b11;
                4'd2:  begin sa = 1; sb2 = 2'b10; end
                4'd3:  begin mq = 1; io = 1; end
                4'd4:  begin rw = 1; mtr = 1; dn = 1; end
                4'd5:  begin mq = 1; io = 1; mw = 1; dn = mr; end
                4'd6:  begin sa = 1; ao = 2'b10; end
                4'd7:  begin rw = 1; rd = 1; dn = 1; end
                4'd8:  begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; dn = 1; end
                4'd9:  begin sa = 1; sb2 = 2'b10; end
                4'd10: begin rw = 1; dn = 1; end
                4'd11: begin ps = 2'b10; pw = 1; dn = 1; end
                4'd12: begin rw = 1; lk = 1; ps = 2'b10; pw = 1; dn = 1; end
                4'd13: ft = 1;
                default: ;
            endcase
        end
        return {mq, mw, ir, pw, br, rw, rd, mtr, io, sa, sb2, ps, ao, lk, dn, ft};
    endfunction

    logic [18:0] obs_ctrl;
    assign obs_ctrl = {memreq, memwrite, irwrite, pcwrite, branch, regwrite, regdst,
                       memtoreg, iord, alusrca, alusrcb, pcsrc, aluop, link, done, fault};

    // Drive one cycle of inputs and queue what the DUT must show in that cycle.
    task automatic step(input logic r, input logic [2:0] o, input logic mr, input logic [3:0] st);
        exp_t e;
        @(posedge clk);
        #1;
        reset    = r;
        op       = o;
        memready = mr;
        e.idx  = n_step;
        e.st   = r ? 4'd0 : st;
        e.ctrl = exp_ctrl(st, mr, r);
        sb.push_back(e);
        n_step++;
    endtask

    // Scoreboard check on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            assert (state === e.st) else begin
                n_bad++;
                $error("FAIL state step=%0d observed=%0d expected=%0d", e.idx, state, e.st);
            end
            n_cmp++;
            assert (obs_ctrl === e.ctrl) else begin
                n_bad++;
                $error("FAIL ctrl step=%0d state=%0d observed=%b expected=%b", e.idx, e.st, obs_ctrl, e.ctrl);
            end
        end
    end

    initial begin
        // Reset held three cycles with memory ready.
        step(1, 3'b000, 1, 0);
        step(1, 3'b000, 1, 0);
        step(1, 3'b000, 1, 0);
        // RTYPE, zero wait.
        step(0, 3'b000, 1, 0);
        step(0, 3'b000, 1, 1);
        step(0, 3'b000, 1, 6);
        step(0, 3'b000, 1, 7);
        // LW with two wait cycles in MEMRD.
        step(0, 3'b001, 1, 0);
        step(0, 3'b001, 1, 1);
        step(0, 3'b001, 1, 2);
        step(0, 3'b001, 0, 3);
        step(0, 3'b001, 0, 3);
        step(0, 3'b001, 1, 3);
        step(0, 3'b001, 1, 4);
        // SW; op changes after DECODE and must be ignored.
        step(0, 3'b010, 1, 0);
        step(0, 3'b010, 1, 1);
        step(0, 3'b001, 1, 2);
        step(0, 3'b001, 0, 5);
        step(0, 3'b001, 1, 5);
        // BEQ after one fetch wait; illegal op outside DECODE is ignored.
        step(0, 3'b100, 0, 0);
        step(0, 3'b100, 1, 0);
        step(0, 3'b101, 1, 1);
        step(0, 3'b101, 1, 8);
        // ADDI.
        step(0, 3'b011, 1, 0);
        step(0, 3'b011, 1, 1);
        step(0, 3'b011, 1, 9);
        step(0, 3'b011, 1, 10);
        // Illegal opcode 100.
        step(0, 3'b100, 1, 0);
        step(0, 3'b100, 1, 1);
        step(0, 3'b100, 1, 13);
        // J.
        step(0, 3'b110, 1, 0);
        step(0, 3'b110, 1, 1);
        step(0, 3'b110, 1, 11);
        // JAL.
        step(0, 3'b111, 1, 0);
        step(0, 3'b111, 1, 1);
        step(0, 3'b111, 1, JAL_ST);
        // Watchdog: sixteen idle FETCH cycles, then FAULT.
        for (int i = 0; i < 16; i++) step(0, 3'b000, 0, 0);
        step(0, 3'b000, 0, 13);
        // Memory completes on the sixteenth cycle: no fault.
        for (int i = 0; i < 15; i++) step(0, 3'b000, 0, 0);
        step(0, 3'b000, 1, 0);
        step(0, 3'b000, 1, 1);
        step(0, 3'b000, 1, 6);
        step(0, 3'b000, 1, 7);
        // Reset in the middle of LW: MEMRD abandoned, outputs zero.
        step(0, 3'b001, 1, 0);
        step(0, 3'b001, 1, 1);
        step(0, 3'b001, 1, 2);
        step(1, 3'b001, 1, 3);
        step(0, 3'b001, 1, 0);
        step(0, 3'b001, 1, 1);
        // Let the last queued entry be checked.
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        assert (sb.size() == 0) else begin
            n_bad++;
            $error("FAIL drain observed=%0d expected=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_maindec.md
# multicycle_maindec

Multicycle main decoder for the 32-bit gigaHurt MIPS-style CPU. It replaces the single-cycle opcode-to-control lookup with a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback steps. It includes a memory ready/request handshake with a watchdog. It sits in the controller next to the ALU decoder and drives the multicycle datapath: PC, IR, register file, ALU muxes and unified memory.

## Interface
- OPW, 3: opcode width. Legal opcodes are the 3-bit values below, zero-extended. Any nonzero bit above bit 2 is illegal.
- WAIT_MAX, 15: maximum consecutive wait cycles with memready low before a fault. 0 disables the watchdog.
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  OPW  opcode from the instruction register, sampled in DECODE
- memready  in  1  memory completed the current access this cycle
- memreq  out  1  memory access requested
- memwrite  out  1  memory write enable
- irwrite  out  1  instruction register load
- pcwrite  out  1  unconditional PC load
- branch  out  1  conditional PC load (BEQ, qualified by zero in the datapath)
- regwrite  out  1  register file write enable
- regdst  out  1  1 selects rd, 0 selects rt
- memtoreg  out  1  1 selects memory data for writeback
- iord  out  1  1 selects ALUOut as memory address, 0 selects PC
- alusrca  out  1  1 selects register A, 0 selects PC
- alusrcb  out  2  00 selects B, 01 selects constant 4, 10 selects signext imm, 11 selects signext imm<<2
- pcsrc  out  2  00 selects ALU result, 01 selects ALUOut, 10 selects jump target
- aluop  out  2  00 add, 01 subtract, 10 funct field
- link  out  1  writeback of PC into r31 (JAL)
- done  out  1  one-cycle pulse in the final state of an instruction
- fault  out  1  one-cycle pulse in FAULT
- state  out  4  current state encoding, for debug

## Operation
- Opcodes: 000 RTYPE, 001 LW, 010 SW, 011 ADDI, 101 BEQ, 110 J, 111 JAL. 100 and any out-of-range value are illegal.
- States and encodings:
  - FETCH 0
  - DECODE 1
  - MEMADR 2
  - MEMRD 3
  - MEMWB 4
  - MEMWR 5
  - EXECUTE 6
  - ALUWB 7
  - BRANCH 8
  - ADDIEX 9
  - ADDIWB 10
  - JUMP 11
  - JALWB 12
  - FAULT 13
  - Codes 14 and 15 are unreachable and go to FETCH.
- Outputs not listed for a state are 0.
- FETCH: memreq=1, alusrcb=01. irwrite=1 and pcwrite=1 only while memready=1. Stays in FETCH until memready=1, then goes to DECODE.
- DECODE: alusrcb=11. Next state by opcode:
  - LW or SW goes to MEMADR.
  - RTYPE goes to EXECUTE.
  - ADDI goes to ADDIEX.
  - BEQ goes to BRANCH.
  - J goes to JUMP.
  - JAL goes to JALWB (see Configuration).
  - An illegal opcode goes to FAULT.
- MEMADR: alusrca=1, alusrcb=10. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: memreq=1, iord=1. Waits for memready, then goes to MEMWB.
- MEMWB: regwrite=1, memtoreg=1, done=1. Goes to FETCH.
- MEMWR: memreq=1, iord=1, memwrite=1, held for the whole wait. Goes to FETCH on memready, with done=1 in that cycle.
- EXECUTE: alusrca=1, aluop=10. Goes to ALUWB.
- ALUWB: regwrite=1, regdst=1, done=1. Goes to FETCH.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1, done=1. Goes to FETCH.
- ADDIEX: alusrca=1, alusrcb=10. Goes to ADDIWB.
- ADDIWB: regwrite=1, done=1. Goes to FETCH.
- JUMP: pcsrc=10, pcwrite=1, done=1. Goes to FETCH.
- JALWB: regwrite=1, link=1, pcsrc=10, pcwrite=1, done=1. Goes to FETCH.
- FAULT: fault=1. All write enables are 0. Goes to FETCH.
- Watchdog:
  - Wait counter width is $clog2(WAIT_MAX+1).
  - The counter increments each cycle in FETCH, MEMRD or MEMWR while memready=0. It clears on any state change and on memready=1.
  - When the counter equals WAIT_MAX and memready is still 0, next state is FAULT.
  - memready=1 in that same cycle wins: normal transition, no fault.

## Timing
- Reset, synchronous: at the first rising edge with reset=1, state becomes FETCH and the wait counter clears.
- While reset is high, all outputs are 0, including memreq, irwrite, pcwrite, regwrite, memwrite and done.
- The first fetch request appears in the cycle after reset deasserts.
- Reset mid-instruction abandons the instruction at once. No partial writeback occurs after the reset edge.
- Outputs are a combinational function of state. Only pcwrite, irwrite and the MEMWR done depend on memready.
- Zero-wait latency, in cycles, FETCH included: RTYPE 4, LW 5, SW 4, ADDI 4, BEQ 3, J 3, JAL 3.
- Each wait cycle adds 1.
- op must be stable in DECODE. It is ignored in all other states.

## Configuration
- MULTICYCLE_MAINDEC_JAL_EN defined: opcode 111 goes DECODE to JALWB, so link, regwrite and the jump are asserted in one state.
- Undefined: opcode 111 goes to JUMP, behaving exactly as J. link is tied to 0 and JALWB (12) is unreachable.

## Test plan
- Reset held 3 cycles with memready=1: all outputs 0 during reset. After release, state=0 with memreq=1, irwrite=1, pcwrite=1.
- RTYPE, memready=1: states 0,1,6,7,0. aluop=10 in EXECUTE. regwrite=1 and regdst=1 with done=1 in cycle 4.
- LW with memready low 2 cycles in MEMRD: states 0,1,2,3,3,3,4. MEMWB has memtoreg=1 and regwrite=1. Total 7 cycles.
- SW then BEQ: MEMWR holds memwrite=1 until memready. BEQ reaches state 8 with branch=1, aluop=01, pcsrc=01.
- op=100 and op=111 (macro off): op=100 gives 0,1,13,0 with one fault pulse. op=111 gives 0,1,11 with link=0. With the macro on, op=111 gives 0,1,12 with link=1, regwrite=1, pcsrc=10.
- WAIT_MAX=15, memready=0 forever from reset: FETCH for 16 cycles, then FAULT, then FETCH. With memready=1 on the 16th cycle, DECODE follows and fault stays 0.
